ivector_arb: RTL and testbench

- Parametrised successor to the fixed 10-channel ping-pong vector block.
- Requests say(meth, v) are steered into one of CHANNELS independent FIFOs of configurable DEPTH, indexed by meth.
- A single output arbiter drains the non-empty channels onto the heard(meth, v) indication.
- Sits between the request decoder and the indication serialiser of the host-interface path.

---
 rtl/ivector_arb_if.sv | 25 ++
 rtl/ivector_arb.sv | 152 +++++++++++++++
 tb/tb_ivector_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ivector_arb_if.sv
// Request/indication bundle for ivector_arb: say(meth, v) in, heard(meth, v) out.
interface ivector_arb_if #(
    parameter int CHANNELS   = 10,
    parameter int DATA_WIDTH = 32,
    parameter int METH_WIDTH = 32
);
    logic                  say__ENA;
    logic [METH_WIDTH-1:0] say_meth;
    logic [DATA_WIDTH-1:0] say_v;
    logic                  say__RDY;
    logic                  heard__ENA;
    logic [METH_WIDTH-1:0] heard_meth;
    logic [DATA_WIDTH-1:0] heard_v;
    logic                  heard__RDY;
    logic [CHANNELS-1:0]   occupancy;

    modport slave (
        input  say__ENA, say_meth, say_v, heard__RDY,
        output say__RDY, heard__ENA, heard_meth, heard_v, occupancy
    );
    modport master (
        output say__ENA, say_meth, say_v, heard__RDY,
        input  say__RDY, heard__ENA, heard_meth, heard_v, occupancy
    );
endinterface

// File: rtl/ivector_arb.sv
// Per-channel FIFOs steered by meth, drained by one output arbiter.
// IVECTOR_ARB_ROUND_ROBIN_EN selects round-robin grant; otherwise fixed lowest-index priority.
module ivector_arb_chan #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  nempty_o,
    output logic                  occ_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  occ_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_i) wptr_d = wrap_inc(wptr_q);
        if (pop_i)  rptr_d = wrap_inc(rptr_q);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            occ_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            occ_q  <= (cnt_d != '0);
        end
    end

    // Storage needs no reset; pointers/count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign head_o   = mem_q[rptr_q];
    assign full_o   = (cnt_q == CW'(DEPTH));
    assign nempty_o = (cnt_q != '0);
    assign occ_o    = occ_q;
endmodule

module ivector_arb #(
    parameter int CHANNELS   = 10,
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int METH_WIDTH = 32
) (
    input  logic          CLK,
    input  logic          RST,
    ivector_arb_if.slave  bus
);
    localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]                 full, nempty, push, pop, occ;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] head;
    logic                                in_range, any, fire;
    logic [GW-1:0]                       sel, g;

    assign in_range     = (bus.say_meth < METH_WIDTH'(CHANNELS));
    assign sel          = bus.say_meth[GW-1:0];
    assign bus.say__RDY = in_range ? !full[sel] : 1'b1;

`ifdef IVECTOR_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] rr_q, rr_d;
    int            idx;

    // First non-empty channel at or after rr_q, wrapping.
    always_comb begin
        g   = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!any && nempty[GW'(idx)]) begin
                any = 1'b1;
                g   = GW'(idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (fire) rr_d = (g == GW'(CHANNELS - 1)) ? '0 : g + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) rr_q <= '0;
        else     rr_q <= rr_d;
    end
`else
    always_comb begin
        g   = '0;
        any = |nempty;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (nempty[GW'(k)]) g = GW'(k);
        end
    end
`endif

    // Nothing fires while reset is being applied.
    assign fire           = any && bus.heard__RDY && !RST;
    assign bus.heard__ENA = fire;
    assign bus.heard_meth = fire ? METH_WIDTH'(g) : '0;
    assign bus.heard_v    = fire ? head[g] : '0;
    assign bus.occupancy  = occ;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign push[i] = bus.say__ENA && in_range && (sel == GW'(i)) && !full[i];
        assign pop[i]  = fire && (g == GW'(i));

        ivector_arb_chan #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_chan (
            .clk_i    (CLK),
            .rst_i    (RST),
            .push_i   (push[i]),
            .pop_i    (pop[i]),
            .din_i    (bus.say_v),
            .head_o   (head[i]),
            .full_o   (full[i]),
            .nempty_o (nempty[i]),
            .occ_o    (occ[i])
        );
    end
endmodule

// File: tb/tb_ivector_arb.sv
// Randomized + directed bench for ivector_arb against a queue-based reference model.
module tb_ivector_arb;
    localparam int CH = 10, DEPTH = 4, DW = 32, MW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ivector_arb_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .METH_WIDTH(MW)) bus();

    ivector_arb #(.CHANNELS(CH), .DEPTH(DEPTH), .DATA_WIDTH(DW), .METH_WIDTH(MW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int              checks = 0, errors = 0;
    logic [DW-1:0]   mq [CH][$];
    int              rr = 0;
    logic            obs_ena, obs_rdy;
    logic [MW-1:0]   obs_meth;
    logic [DW-1:0]   obs_v;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int grant();
        int idx;
        for (int k = 0; k < CH; k++) begin
`ifdef IVECTOR_ARB_ROUND_ROBIN_EN
            idx = (rr + k) % CH;
`else
            idx = k;
`endif
            if (mq[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    function automatic bit model_rdy(input int meth);
        if (meth >= CH) return 1'b1;
        return mq[meth].size() < DEPTH;
    endfunction

    // One clock: drive, check at negedge, advance model at posedge.
    task automatic cyc(input bit ena, input int meth, input logic [DW-1:0] v, input bit rdy, input bit r);
        int            g;
        bit            efire;
        logic [CH-1:0] occ;
        logic [DW-1:0] ev;
        rst = r;
        bus.say__ENA   = ena;
        bus.say_meth   = MW'(meth);
        bus.say_v      = v;
        bus.heard__RDY = rdy;
        @(negedge clk);
        g     = grant();
        efire = (g >= 0) && rdy && !r;
        ev    = '0;
        if (efire) ev = mq[g][0];
        for (int k = 0; k < CH; k++) occ[k] = (mq[k].size() != 0);
        chk("say_rdy", {63'b0, bus.say__RDY}, {63'b0, model_rdy(meth)});
        chk("heard_ena", {63'b0, bus.heard__ENA}, {63'b0, efire});
        chk("heard_meth", 64'(bus.heard_meth), efire ? 64'(g) : 64'd0);
        chk("heard_v", 64'(bus.heard_v), 64'(ev));
        chk("occupancy", 64'(bus.occupancy), 64'(occ));
        obs_ena  = bus.heard__ENA;
        obs_rdy  = bus.say__RDY;
        obs_meth = bus.heard_meth;
        obs_v    = bus.heard_v;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < CH; k++) mq[k].delete();
            rr = 0;
        end else begin
            if (efire) begin
                void'(mq[g].pop_front());
                rr = (g + 1) % CH;
            end
            if (ena && meth < CH) mq[meth].push_back(v);
        end
        #1;
    endtask

    initial begin
        int arb_m[4], arb_v[4];
        int meth;
        bit ena, rdy, r;
        rst = 1'b1;
        bus.say__ENA = 1'b0; bus.say_meth = '0; bus.say_v = '0; bus.heard__RDY = 1'b1;
        @(posedge clk); #1;
        cyc(0, 0, 0, 1, 1);
        repeat (10) cyc(0, 0, 0, 1, 0);

        // single channel, 1-cycle latency
        cyc(1, 3, 32'hA5A5_0001, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("single_ena", {63'b0, obs_ena}, 64'd1);
        chk("single_meth", 64'(obs_meth), 64'd3);
        chk("single_v", 64'(obs_v), 64'hA5A5_0001);
        cyc(0, 0, 0, 1, 0);

        // fill + backpressure
        for (int i = 1; i <= 4; i++) cyc(1, 5, DW'(i), 0, 0);
        cyc(0, 5, 0, 0, 0);
        chk("full_rdy5", {63'b0, obs_rdy}, 64'd0);
        cyc(0, 6, 0, 0, 0);
        chk("rdy6", {63'b0, obs_rdy}, 64'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("drain_v", 64'(obs_v), 64'(i));
        end

        // arbitration order
        cyc(1, 0, 10, 0, 0); cyc(1, 0, 11, 0, 0);
        cyc(1, 2, 20, 0, 0); cyc(1, 2, 21, 0, 0);
`ifdef IVECTOR_ARB_ROUND_ROBIN_EN
        arb_m = '{0, 2, 0, 2}; arb_v = '{10, 20, 11, 21};
`else
        arb_m = '{0, 0, 2, 2}; arb_v = '{10, 11, 20, 21};
`endif
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("arb_meth", 64'(obs_meth), 64'(arb_m[i]));
            chk("arb_v", 64'(obs_v), 64'(arb_v[i]));
        end

        // out-of-range dropped
        cyc(1, CH, 32'hDEAD, 1, 0);
        chk("oor_rdy", {63'b0, obs_rdy}, 64'd1);
        repeat (3) cyc(0, 0, 0, 1, 0);

        // concurrent push/pop on ch1
        cyc(1, 1, 100, 0, 0);
        cyc(1, 1, 101, 1, 0);
        chk("conc_v0", 64'(obs_v), 64'd100);
        cyc(0, 0, 0, 1, 0);
        chk("conc_v1", 64'(obs_v), 64'd101);

        // reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1, 7, DW'(70 + i), 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("rst_ena", {63'b0, obs_ena}, 64'd0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        cyc(1, 9, 90, 0, 0); cyc(1, 1, 11, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("post_rst_g", 64'(obs_meth), 64'd1);
        cyc(0, 0, 0, 1, 0);
        chk("post_rst_g2", 64'(obs_meth), 64'd9);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            meth = int'($urandom_range(0, CH));
            ena  = ($urandom_range(0, 1) == 1) && model_rdy(meth);
            rdy  = ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 99) == 0);
            cyc(ena, meth, DW'($urandom), rdy, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
